// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with clock enable, per-word shift counter and a registered word-done pulse.
module universal_shift_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sInR,
  input  logic             sInL,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] PO,
  output logic             SOR,
  output logic             SOL,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0]    MODE_HOLD  = 2'b00;
  localparam logic [1:0]    MODE_SHR   = 2'b01;
  localparam logic [1:0]    MODE_SHL   = 2'b10;
  localparam logic [1:0]    MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_po;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_po_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_shift;
  logic             w_wrap;

  // Both shift directions advance the same word counter.
  assign w_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign w_wrap  = (r_cnt == CNT_LAST);

  // Next-state selection; disabled or hold keeps PO/cnt and drops done.
  always_comb begin
    w_po_nxt   = r_po;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHR:  w_po_nxt = {sInR, r_po[WIDTH-1:1]};
        MODE_SHL:  w_po_nxt = {r_po[WIDTH-2:0], sInL};
        MODE_LOAD: begin
          w_po_nxt  = PI;
          w_cnt_nxt = '0;
        end
        default: ;
      endcase
    end
    if (w_shift) begin
      w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
      w_done_nxt = w_wrap;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_po   <= RST_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_po   <= w_po_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign PO   = r_po;
  assign SOR  = r_po[0];
  assign SOL  = r_po[WIDTH-1];
  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8 and WIDTH=5 instances).
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, sInR, sInL;
  logic [1:0] mode;
  logic [7:0] PI, PO;
  logic       SOR, SOL, done;
  logic [2:0] cnt;

  logic       en5, sInR5, sInL5;
  logic [1:0] mode5;
  logic [4:0] PI5, PO5;
  logic       SOR5, SOL5, done5;
  logic [2:0] cnt5;

  int n_vec = 0;
  int n_err = 0;

  universal_shift_register #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sInR(sInR), .sInL(sInL),
    .PI(PI), .PO(PO), .SOR(SOR), .SOL(SOL), .cnt(cnt), .done(done)
  );

  universal_shift_register #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .en(en5), .mode(mode5), .sInR(sInR5), .sInL(sInL5),
    .PI(PI5), .PO(PO5), .SOR(SOR5), .SOL(SOL5), .cnt(cnt5), .done(done5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sr_bits;
    logic [7:0] sol_exp;
    rst = 1'b0; en = 1'b1; mode = 2'b00; sInR = 1'b0; sInL = 1'b0; PI = '0;
    en5 = 1'b1; mode5 = 2'b00; sInR5 = 1'b0; sInL5 = 1'b0; PI5 = '0;
    #12;
    chk("rst_po", PO, 8'h00);
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_po5", PO5, 5'h00);
    rst = 1'b1;

    // 1: async reset mid-cycle
    mode = 2'b11; PI = 8'hA5; step();
    chk("t1_load", PO, 8'hA5);
    chk("t1_sor", SOR, 1);
    chk("t1_sol", SOL, 1);
    #3 rst = 1'b0;
    #1;
    chk("t1_async_po", PO, 8'h00);
    chk("t1_async_cnt", cnt, 0);
    chk("t1_async_done", done, 0);
    #1 rst = 1'b1;

    // 2: right shift of 1,0,1,1,0,0,1,0
    sr_bits = 8'b01001101; // bit i = i-th serial input
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      sInR = sr_bits[i];
      step();
      chk($sformatf("t2_cnt%0d", i), cnt, (i + 1) % 8);
      chk($sformatf("t2_done%0d", i), done, (i == 7));
    end
    chk("t2_po", PO, 8'b01001101);
    mode = 2'b00; step();
    chk("t2_done_drop", done, 0);
    chk("t2_hold_po", PO, 8'b01001101);

    // 3: load C3 then left shift zeros, watching SOL
    mode = 2'b11; PI = 8'hC3; step();
    chk("t3_load_cnt", cnt, 0);
    sol_exp = 8'b11000011; // bit 7 = first SOL observed
    mode = 2'b10; sInL = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_sol%0d", i), SOL, sol_exp[7-i]);
      step();
      chk($sformatf("t3_done%0d", i), done, (i == 7));
    end
    chk("t3_po", PO, 8'h00);

    // 4: 3 shifts, 5 disabled cycles, 5 shifts
    mode = 2'b01; sInR = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t4_po3", PO, 8'hE0);
    chk("t4_cnt3", cnt, 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_frz_po%0d", i), PO, 8'hE0);
      chk($sformatf("t4_frz_cnt%0d", i), cnt, 3);
      chk($sformatf("t4_frz_done%0d", i), done, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_done%0d", i), done, (i == 4));
    end
    chk("t4_po", PO, 8'hFF);
    chk("t4_cnt", cnt, 0);

    // 5: load wins over completing shift; then reset mid-word
    mode = 2'b01; sInR = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t5_cnt7", cnt, 7);
    mode = 2'b11; PI = 8'h5A; step();
    chk("t5_po", PO, 8'h5A);
    chk("t5_cnt", cnt, 0);
    chk("t5_done", done, 0);
    mode = 2'b10; sInL = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t5_po3", PO, 8'hD7);
    chk("t5_cnt3", cnt, 3);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_po", PO, 8'h00);
    chk("t5_rst_cnt", cnt, 0);
    chk("t5_rst_done", done, 0);
    #1 rst = 1'b1;
    mode = 2'b00; step();
    chk("t5_after_done", done, 0);
    chk("t5_after_cnt", cnt, 0);

    // 5b: direction change keeps counting
    mode = 2'b01; sInR = 1'b0;
    for (int i = 0; i < 4; i++) step();
    mode = 2'b10; sInL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5b_done%0d", i), done, (i == 3));
    end

    // 6: WIDTH=5 continuous right shift
    mode5 = 2'b01; sInR5 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("t6_cnt%0d", i), cnt5, (i + 1) % 5);
      chk($sformatf("t6_done%0d", i), done5, (i % 5 == 4));
      if (i == 4) chk("t6_po", PO5, 5'h1F);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
